// File: rtl/mem_responder_if.sv
// Bundle of the CPU-facing memory signals: data read/write port, fetch port and debug status.
// The master drives requests; the slave (mem_responder) drives responses and status.
interface mem_responder_if;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_iren;
    logic [63:0] mem_iraddr;
    logic        mem_irvalid;
    logic [63:0] mem_irdata;
    logic        oob_error;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    modport master (
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_iren, mem_iraddr,
        input  mem_rvalid, mem_rdata, mem_irvalid, mem_irdata, oob_error, rd_count, wr_count
    );

    modport slave (
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_iren, mem_iraddr,
        output mem_rvalid, mem_rdata, mem_irvalid, mem_irdata, oob_error, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// 2R1W word-addressed 64-bit store answering data and fetch reads after READ_LATENCY cycles.
// Store contents power up undefined and are never touched by reset.
module mem_responder #(
    parameter int WORD_BITS    = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << WORD_BITS;
    localparam int LAT   = READ_LATENCY;

    logic [63:0] mem_q [DEPTH];

    logic [WORD_BITS-1:0] r_idx, i_idx, w_idx;
    logic                 r_oob, i_oob, w_oob, w_ok;
    logic [63:0]          r_word, i_word;

    assign r_idx = bus.mem_raddr[WORD_BITS+2:3];
    assign i_idx = bus.mem_iraddr[WORD_BITS+2:3];
    assign w_idx = bus.mem_waddr[WORD_BITS+2:3];
    assign r_oob = |bus.mem_raddr[63:WORD_BITS+3];
    assign i_oob = |bus.mem_iraddr[63:WORD_BITS+3];
    assign w_oob = |bus.mem_waddr[63:WORD_BITS+3];
    assign w_ok  = bus.mem_wen && !w_oob;

    // Write-first bypass: a same-edge write to the read word wins over the stored value.
    always_comb begin
        r_word = mem_q[r_idx];
        if (r_oob)                        r_word = '0;
        else if (w_ok && w_idx == r_idx)  r_word = bus.mem_wdata;
        i_word = mem_q[i_idx];
        if (i_oob)                        i_word = '0;
        else if (w_ok && w_idx == i_idx)  i_word = bus.mem_wdata;
    end

    logic unused_lsbs;
    assign unused_lsbs = ^{bus.mem_raddr[2:0], bus.mem_iraddr[2:0], bus.mem_waddr[2:0]};

    logic [LAT-1:0]       r_vld_q, r_vld_d, i_vld_q, i_vld_d;
    logic [LAT-1:0][63:0] r_dat_q, r_dat_d, i_dat_q, i_dat_d;

    always_comb begin
        r_vld_d    = r_vld_q;
        r_dat_d    = r_dat_q;
        i_vld_d    = i_vld_q;
        i_dat_d    = i_dat_q;
        r_vld_d[0] = bus.mem_ren;
        r_dat_d[0] = bus.mem_ren ? r_word : '0;
        i_vld_d[0] = bus.mem_iren;
        i_dat_d[0] = bus.mem_iren ? i_word : '0;
        for (int k = 1; k < LAT; k++) begin
            r_vld_d[k] = r_vld_q[k-1];
            r_dat_d[k] = r_dat_q[k-1];
            i_vld_d[k] = i_vld_q[k-1];
            i_dat_d[k] = i_dat_q[k-1];
        end
    end

    logic [1:0]  rd_inc;
    logic [31:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic        oob_q, oob_d;

    always_comb begin
        rd_inc     = {1'b0, bus.mem_ren} + {1'b0, bus.mem_iren};
        rd_count_d = (rd_count_q > (32'hFFFF_FFFF - {30'd0, rd_inc})) ? 32'hFFFF_FFFF
                                                                      : rd_count_q + {30'd0, rd_inc};
        wr_count_d = (bus.mem_wen && wr_count_q != 32'hFFFF_FFFF) ? wr_count_q + 32'd1 : wr_count_q;
        oob_d      = oob_q | (bus.mem_ren & r_oob) | (bus.mem_iren & i_oob) | (bus.mem_wen & w_oob);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q    <= '0;
            r_dat_q    <= '0;
            i_vld_q    <= '0;
            i_dat_q    <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            r_vld_q    <= r_vld_d;
            r_dat_q    <= r_dat_d;
            i_vld_q    <= i_vld_d;
            i_dat_q    <= i_dat_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            oob_q      <= oob_d;
        end
    end

    // Kept reset-free so the array maps onto RAM; writes are not accepted while in reset.
    always_ff @(posedge clk) begin
        if (!rst && w_ok) mem_q[w_idx] <= bus.mem_wdata;
    end

    assign bus.mem_rvalid  = r_vld_q[LAT-1];
    assign bus.mem_rdata   = r_dat_q[LAT-1];
    assign bus.mem_irvalid = i_vld_q[LAT-1];
    assign bus.mem_irdata  = i_dat_q[LAT-1];
    assign bus.oob_error   = oob_q;
    assign bus.rd_count    = rd_count_q;
    assign bus.wr_count    = wr_count_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed table, hand sequences for reset/streaming, and random traffic
// checked every cycle against a queue-and-associative-array model of the memory.
module tb_mem_responder;
    localparam int WB  = 14;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if bus();
    mem_responder #(.WORD_BITS(WB), .READ_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic v; logic [63:0] d; } resp_t;
    resp_t       dq[$], iq[$];
    logic [63:0] store [longint];
    logic        m_oob;
    logic [31:0] m_rc, m_wc;
    int          vectors = 0, misc = 0;

    function automatic logic is_oob(input logic [63:0] a);
        return (a >> (WB + 3)) != 64'd0;
    endfunction

    function automatic longint widx(input logic [63:0] a);
        return longint'((a >> 3) % (64'd1 << WB));
    endfunction

    function automatic logic [63:0] rd_model(input logic en, input logic [63:0] a,
                                             input logic wen, input logic [63:0] wa, input logic [63:0] wd);
        if (!en || is_oob(a)) return 64'd0;
        if (wen && !is_oob(wa) && widx(wa) == widx(a)) return wd;
        if (store.exists(widx(a))) return store[widx(a)];
        return 'x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic r, input logic ren, input logic [63:0] ra,
                       input logic wen, input logic [63:0] wa, input logic [63:0] wd,
                       input logic iren, input logic [63:0] ia);
        resp_t nd, ni, ed, ei;
        logic [32:0] t;
        rst = r; bus.mem_ren = ren; bus.mem_raddr = ra; bus.mem_wen = wen;
        bus.mem_waddr = wa; bus.mem_wdata = wd; bus.mem_iren = iren; bus.mem_iraddr = ia;
        ed.v = 1'b0; ed.d = 64'd0; ei.v = 1'b0; ei.d = 64'd0;
        if (r) begin
            dq.delete(); iq.delete();
            m_oob = 1'b0; m_rc = 32'd0; m_wc = 32'd0;
        end else begin
            nd.v = ren;  nd.d = rd_model(ren, ra, wen, wa, wd);
            ni.v = iren; ni.d = rd_model(iren, ia, wen, wa, wd);
            dq.push_back(nd); iq.push_back(ni);
            if ((ren && is_oob(ra)) || (iren && is_oob(ia)) || (wen && is_oob(wa))) m_oob = 1'b1;
            t = {1'b0, m_rc} + 33'(ren) + 33'(iren);
            m_rc = t[32] ? 32'hFFFF_FFFF : t[31:0];
            if (wen && m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 32'd1;
            if (wen && !is_oob(wa)) store[widx(wa)] = wd;
            if (dq.size() == LAT) ed = dq.pop_front();
            if (iq.size() == LAT) ei = iq.pop_front();
        end
        @(posedge clk); #1;
        chk("rvalid", 64'(bus.mem_rvalid), 64'(ed.v));
        if (ed.v || r) chk("rdata", bus.mem_rdata, ed.d);
        chk("irvalid", 64'(bus.mem_irvalid), 64'(ei.v));
        if (ei.v || r) chk("irdata", bus.mem_irdata, ei.d);
        chk("oob_error", 64'(bus.oob_error), 64'(m_oob));
        chk("rd_count", 64'(bus.rd_count), 64'(m_rc));
        chk("wr_count", 64'(bus.wr_count), 64'(m_wc));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic ren; logic [63:0] ra; logic wen; logic [63:0] wa, wd; logic iren; logic [63:0] ia;
        logic e_rv; logic [63:0] e_rd; logic e_irv; logic [63:0] e_ird; logic e_oob; logic [31:0] e_wc;
    } vec_t;
    vec_t tbl[14];

    localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PAT  = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] FAR  = 64'h1_0000_0000;

    initial begin
        logic [63:0] stream [4];
        logic [63:0] ra, ia, wa;

        // ren ra wen wa wd iren ia | rv rd irv ird oob wc
        tbl[0]  = '{1, 64'h80, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 33};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,                 1, BEEF, 0, 0, 0, 33};
        tbl[2]  = '{1, 64'h47, 1, 64'h40, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 34};
        tbl[3]  = '{0, 0, 1, 64'h40, 64'h5678, 0, 0,     1, 64'h1234, 0, 0, 0, 35};
        tbl[4]  = '{1, 64'h40, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 35};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0,                 1, 64'h5678, 0, 0, 0, 35};
        tbl[6]  = '{1, FAR, 0, 0, 0, 0, 0,               0, 0, 0, 0, 1, 35};
        tbl[7]  = '{0, 0, 1, FAR, 64'hFFFF, 0, 0,        1, 0, 0, 0, 1, 36};
        tbl[8]  = '{1, 64'h0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 36};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,                 1, PAT, 0, 0, 1, 36};
        tbl[10] = '{1, 64'h8, 1, 64'h18, 64'hBBBB, 1, 64'h10, 0, 0, 0, 0, 1, 37};
        tbl[11] = '{1, 64'h18, 0, 0, 0, 0, 0,            1, PAT | 64'd1, 1, PAT | 64'd2, 1, 37};
        tbl[12] = '{0, 0, 1, 64'h20, 64'hCC, 1, 64'h27,  1, 64'hBBBB, 0, 0, 1, 38};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0,                 0, 0, 1, 64'hCC, 1, 38};

        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 32; w++) cyc(0, 0, 0, 1, 64'(w * 8), PAT | 64'(w), 0, 0);
        cyc(0, 0, 0, 1, 64'h80, BEEF, 0, 0);

        for (int k = 0; k < 14; k++) begin
            cyc(0, tbl[k].ren, tbl[k].ra, tbl[k].wen, tbl[k].wa, tbl[k].wd, tbl[k].iren, tbl[k].ia);
            chk($sformatf("t%0d_rvalid", k), 64'(bus.mem_rvalid), 64'(tbl[k].e_rv));
            if (tbl[k].e_rv) chk($sformatf("t%0d_rdata", k), bus.mem_rdata, tbl[k].e_rd);
            chk($sformatf("t%0d_irvalid", k), 64'(bus.mem_irvalid), 64'(tbl[k].e_irv));
            if (tbl[k].e_irv) chk($sformatf("t%0d_irdata", k), bus.mem_irdata, tbl[k].e_ird);
            chk($sformatf("t%0d_oob", k), 64'(bus.oob_error), 64'(tbl[k].e_oob));
            chk($sformatf("t%0d_wr_count", k), 64'(bus.wr_count), 64'(tbl[k].e_wc));
        end

        // Reset lands while a data and a fetch read are in flight.
        cyc(0, 1, 64'h80, 0, 0, 0, 1, 64'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rvalid", 64'(bus.mem_rvalid), 64'd0);
        chk("rst_irvalid", 64'(bus.mem_irvalid), 64'd0);
        chk("rst_oob", 64'(bus.oob_error), 64'd0);
        chk("rst_rd_count", 64'(bus.rd_count), 64'd0);
        chk("rst_wr_count", 64'(bus.wr_count), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            chk("post_rst_rvalid", 64'(bus.mem_rvalid), 64'd0);
            chk("post_rst_irvalid", 64'(bus.mem_irvalid), 64'd0);
        end

        stream[0] = PAT; stream[1] = PAT | 64'd1; stream[2] = PAT | 64'd2; stream[3] = 64'hBBBB;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 0, 0, 0, k < 4, 64'(k * 8));
            chk($sformatf("stream%0d_irvalid", k), 64'(bus.mem_irvalid), 64'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk($sformatf("stream%0d_irdata", k), bus.mem_irdata, stream[k-1]);
        end
        chk("stream_rd_count", 64'(bus.rd_count), 64'd4);

        cyc(0, 1, 64'h80, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("store_kept_rvalid", 64'(bus.mem_rvalid), 64'd1);
        chk("store_kept_rdata", bus.mem_rdata, BEEF);

        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 15) == 0) ? {24'h0, 8'($urandom_range(1, 255)), 32'($urandom)}
                                              : 64'($urandom_range(0, 255));
            ia = ($urandom_range(0, 15) == 0) ? {24'h0, 8'($urandom_range(1, 255)), 32'($urandom)}
                                              : 64'($urandom_range(0, 255));
            wa = ($urandom_range(0, 15) == 0) ? {24'h0, 8'($urandom_range(1, 255)), 32'($urandom)}
                                              : 64'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0)
                cyc(1, 0, 0, 0, 0, 0, 0, 0);
            else
                cyc(0, 1'($urandom), ra, 1'($urandom), wa, {32'($urandom), 32'($urandom)}, 1'($urandom), ia);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
